packet_buffer_fifo: RTL and testbench
=====================================

# packet_buffer_fifo

Store-and-forward packet FIFO. Accepts a word stream in which a flag marks the last word of each packet. A packet is released to the output only once it has been completely buffered, so the consumer sees the packet length together with the first word. It sits between a producer that emits packets word-by-word and a consumer, such as a framer, that must know the length before transmitting.

## Interface
- DATA_BITS, 8, width of one data word
- LENGTH_BITS, 8, width of the packet-length field; BUFFER_SIZE must be ≤ 2^LENGTH_BITS − 1
- BUFFER_SIZE, 16, word capacity; power of two, ≥ 2
- clk  in  1  single clock; all logic on rising edge
- rst  in  1  synchronous, active-high reset
- in_full  out  1  buffer cannot accept a word this cycle
- in_shift  in  1  write in_data/in_end this cycle; ignored while in_full=1
- in_data  in  DATA_BITS  input word
- in_end  in  1  word is the last of its packet
- out_pop  in  1  consume head word; ignored while out_nempty=0
- out_nempty  out  1  at least one complete packet is buffered
- out_data  out  DATA_BITS  head word, first-word-fall-through
- out_length  out  LENGTH_BITS  word count of the head packet; constant for the whole packet
- out_start  out  1  head word is the first word of its packet
- out_end  out  1  head word is the last word of its packet

## Operation
- Data store: BUFFER_SIZE entries of {end flag, data}, with write pointer, read pointer and word count.
- Length store: BUFFER_SIZE entries of LENGTH_BITS, with its own pointers and a complete-packet count.
- Accumulator cur_len counts words of the packet currently being written.
- Push (in_shift & !in_full):
  - Write the word at the write pointer and increment cur_len.
  - If the effective end flag is set, push cur_len+1 into the length store and clear cur_len.
- Forced end: if a push fills the data store (count becomes BUFFER_SIZE) and that word is not flagged end, the stored end flag is forced to 1 and the packet is closed. This splits oversize packets into chunks of BUFFER_SIZE words and prevents deadlock. Subsequent words start a new packet.
- Pop (out_pop & out_nempty):
  - Advance the read pointer and decrement the word count.
  - If the head word's end flag is set, pop the length store and set out_start=1.
  - Otherwise clear out_start.
- Outputs:
  - out_nempty = (complete-packet count ≠ 0).
  - out_data and out_end are read combinationally from the data store at the read pointer.
  - out_length is read combinationally from the length-store head.
  - These three are don't-care while out_nempty=0.
- in_full = (word count == BUFFER_SIZE).
- Pointers wrap modulo BUFFER_SIZE.

## Timing
- Reset (rst=1 at an edge): all pointers, counts and cur_len = 0; in_full=0; out_nempty=0; out_start=1. Memory contents are not cleared.
- Reset asserted mid-packet discards all buffered and partial data.
- Push-to-visible latency: a word with in_end accepted at edge N makes out_nempty=1 after edge N, so it can be popped in the cycle following N.
- out_start, out_data and out_end update after each pop edge.
- in_full and out_nempty are register-derived, with no combinational path from in_shift or out_pop.
- Simultaneous push and pop in one cycle are both performed; the word count is unchanged.
- Simultaneous push-completing-packet and pop-ending-packet: both the packet count and the length store stay consistent (net 0).
- A pop while out_nempty=0 or a push while in_full=1 has no effect.
- Freeing one word deasserts in_full on the next cycle.

## Test plan
- Reset, then push words 0..19 cyclically with in_end at indices 2,4,6,7,10, using random in_shift/out_pop. Pops must print "start-3 0 1 2 end", "start-2 3 4 end", "start-2 5 6 end", "start-1 7 end", "start-3 8 9 10 end", then "start-12 11..19 0 1 2 end", repeating.
- Push 3 words with in_end only on the last, and hold out_pop=0. out_nempty must stay 0 after words 1–2 and be 1 the cycle after word 3, with out_length=3, out_start=1, out_data=word0.
- Push 16 words with no in_end. in_full=1 after the 16th, out_nempty=1 and out_length=16. Pop all 16; out_end=1 on the 16th only, and in_full drops after the first pop.
- Fill with 16 one-word packets, then push and pop simultaneously on every cycle. No words are lost or duplicated, and each word shows out_start=out_end=1 with out_length=1.
- Assert rst mid-packet with 5 words buffered. The next cycle shows out_nempty=0 and in_full=0. A new 2-word packet then reads out as "start-2" with the correct data.
- Hold out_pop=1 while out_nempty=0 and push a partial packet. No state change occurs; the packet later pops intact.

Source files
------------

// File: rtl/packet_buffer_fifo_if.sv
// Handshake bundle between a packet producer, the store-and-forward FIFO
// and a packet consumer.
//
// Handshake semantics: a word moves into the FIFO on a rising clock edge
// where in_shift=1 and in_full=0. A word leaves the FIFO on a rising clock
// edge where out_pop=1 and out_nempty=1. In any other cycle in_shift and
// out_pop are ignored. in_full and out_nempty come straight from registers,
// so neither depends on in_shift or out_pop in the same cycle.
interface packet_buffer_fifo_if #(
  parameter int DATA_BITS   = 8,
  parameter int LENGTH_BITS = 8
);
  logic                   in_full;
  logic                   in_shift;
  logic [DATA_BITS-1:0]   in_data;
  logic                   in_end;
  logic                   out_pop;
  logic                   out_nempty;
  logic [DATA_BITS-1:0]   out_data;
  logic [LENGTH_BITS-1:0] out_length;
  logic                   out_start;
  logic                   out_end;

  // Producer/consumer side.
  modport master (
    input  in_full,
    output in_shift, in_data, in_end,
    output out_pop,
    input  out_nempty, out_data, out_length, out_start, out_end
  );

  // FIFO side.
  modport slave (
    output in_full,
    input  in_shift, in_data, in_end,
    input  out_pop,
    output out_nempty, out_data, out_length, out_start, out_end
  );
endinterface

// File: rtl/packet_buffer_fifo.sv
// Store-and-forward packet FIFO. Words are held until the last word of their
// packet arrives, so the consumer sees the packet length with the first word.
// Packets longer than the buffer are cut into buffer-sized chunks.
module packet_buffer_fifo #(
  parameter int DATA_BITS   = 8,
  parameter int LENGTH_BITS = 8,
  parameter int BUFFER_SIZE = 16
) (
  input logic                 clk,
  input logic                 rst,
  packet_buffer_fifo_if.slave bus
);
  localparam int AW = $clog2(BUFFER_SIZE);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(BUFFER_SIZE);
  localparam logic [AW:0] LAST_CNT = (AW+1)'(BUFFER_SIZE - 1);

  // Each data entry is {end flag, data word}.
  logic [DATA_BITS:0]     data_mem [BUFFER_SIZE];
  logic [LENGTH_BITS-1:0] len_mem  [BUFFER_SIZE];

  logic [AW-1:0]          wr_ptr, rd_ptr;
  logic [AW-1:0]          len_wr_ptr, len_rd_ptr;
  logic [AW:0]            word_cnt;
  logic [AW:0]            pkt_cnt;
  logic [LENGTH_BITS-1:0] cur_len;
  logic                   start_q;

  logic full, nempty, push, pop, force_end, eff_end, head_end;
  logic pkt_push, pkt_pop;

  assign full     = (word_cnt == FULL_CNT);
  assign nempty   = (pkt_cnt != '0);
  assign push     = bus.in_shift & ~full;
  assign pop      = bus.out_pop & nempty;
  assign head_end = data_mem[rd_ptr][DATA_BITS];

  // A push that leaves the buffer completely full must close its packet,
  // otherwise an oversize packet could never become poppable.
  assign force_end = push & ~pop & (word_cnt == LAST_CNT);
  assign eff_end   = bus.in_end | force_end;
  assign pkt_push  = push & eff_end;
  assign pkt_pop   = pop & head_end;

  // Storage writes; contents are intentionally left uninitialised on reset.
  always_ff @(posedge clk) begin
    if (push) data_mem[wr_ptr] <= {eff_end, bus.in_data};
    if (pkt_push) len_mem[len_wr_ptr] <= cur_len + 1'b1;
  end

  // Pointers, occupancy counts, running packet length and start marker.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      len_wr_ptr <= '0;
      len_rd_ptr <= '0;
      word_cnt   <= '0;
      pkt_cnt    <= '0;
      cur_len    <= '0;
      start_q    <= 1'b1;
    end else begin
      if (push) begin
        wr_ptr  <= wr_ptr + 1'b1;
        cur_len <= eff_end ? '0 : cur_len + 1'b1;
      end
      if (pkt_push) len_wr_ptr <= len_wr_ptr + 1'b1;
      if (pop) begin
        rd_ptr  <= rd_ptr + 1'b1;
        start_q <= head_end;
      end
      if (pkt_pop) len_rd_ptr <= len_rd_ptr + 1'b1;

      case ({push, pop})
        2'b10:   word_cnt <= word_cnt + 1'b1;
        2'b01:   word_cnt <= word_cnt - 1'b1;
        default: word_cnt <= word_cnt;
      endcase

      case ({pkt_push, pkt_pop})
        2'b10:   pkt_cnt <= pkt_cnt + 1'b1;
        2'b01:   pkt_cnt <= pkt_cnt - 1'b1;
        default: pkt_cnt <= pkt_cnt;
      endcase
    end
  end

  assign bus.in_full    = full;
  assign bus.out_nempty = nempty;
  assign bus.out_data   = data_mem[rd_ptr][DATA_BITS-1:0];
  assign bus.out_end    = head_end;
  assign bus.out_length = len_mem[len_rd_ptr];
  assign bus.out_start  = start_q;
endmodule

// File: tb/tb_packet_buffer_fifo.sv
// Directed and randomised bench for packet_buffer_fifo with a word-level
// scoreboard of {start, end, length, data} for every word that should pop.
module tb_packet_buffer_fifo;
  localparam int DW = 8;
  localparam int LW = 8;
  localparam int BS = 16;
  localparam int W  = 2 + LW + DW;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  packet_buffer_fifo_if #(.DATA_BITS(DW), .LENGTH_BITS(LW)) u_bus ();

  packet_buffer_fifo #(.DATA_BITS(DW), .LENGTH_BITS(LW), .BUFFER_SIZE(BS)) dut (
    .clk (clk),
    .rst (rst),
    .bus (u_bus.slave)
  );

  int total = 0;
  int bad   = 0;
  logic [W-1:0]  exp_q[$];
  logic [DW-1:0] part_q[$];
  int mcnt = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Move the open packet's words into the expected-output queue.
  task automatic close_packet();
    int len;
    logic [W-1:0] e;
    len = part_q.size();
    for (int i = 0; i < len; i++) begin
      e = {(i == 0), (i == len - 1), LW'(len), part_q[i]};
      exp_q.push_back(e);
    end
    part_q.delete();
  endtask

  // One clock cycle: drive, check before the edge, update the model.
  task automatic step(input logic sh, input logic [DW-1:0] d, input logic e,
                      input logic pp, output bit acc);
    bit push_ok, pop_ok, force_e;
    u_bus.in_shift = sh;
    u_bus.in_data  = d;
    u_bus.in_end   = e;
    u_bus.out_pop  = pp;
    @(negedge clk);
    chk("in_full", {31'd0, u_bus.in_full}, {31'd0, mcnt == BS});
    chk("out_nempty", {31'd0, u_bus.out_nempty}, {31'd0, exp_q.size() != 0});
    if (exp_q.size() != 0)
      chk("head", {14'd0, u_bus.out_start, u_bus.out_end, u_bus.out_length, u_bus.out_data},
          {14'd0, exp_q[0]});
    push_ok = sh && (mcnt != BS);
    pop_ok  = pp && (exp_q.size() != 0);
    force_e = push_ok && !pop_ok && (mcnt == BS - 1) && !e;
    if (pop_ok) begin
      void'(exp_q.pop_front());
      mcnt--;
    end
    if (push_ok) begin
      part_q.push_back(d);
      mcnt++;
      if (e || force_e) close_packet();
    end
    acc = push_ok;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    u_bus.in_shift = 1'b0;
    u_bus.out_pop  = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    exp_q.delete();
    part_q.delete();
    mcnt = 0;
    @(negedge clk);
    chk("rst_in_full", {31'd0, u_bus.in_full}, 32'd0);
    chk("rst_out_nempty", {31'd0, u_bus.out_nempty}, 32'd0);
    chk("rst_out_start", {31'd0, u_bus.out_start}, 32'd1);
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    bit acc;
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      step(1'b0, '0, 1'b0, 1'b1, acc);
      n++;
    end
    step(1'b0, '0, 1'b0, 1'b0, acc);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bit acc;
    int idx;
    int n;
    logic is_end;
    rst = 1'b1;
    u_bus.in_shift = 1'b0;
    u_bus.in_data  = '0;
    u_bus.in_end   = 1'b0;
    u_bus.out_pop  = 1'b0;
    do_reset();

    // Cyclic 0..19 stream with packet ends at 2,4,6,7,10 and random handshakes.
    idx = 0;
    repeat (400) begin
      is_end = (idx == 2) || (idx == 4) || (idx == 6) || (idx == 7) || (idx == 10);
      step($urandom_range(0, 3) != 0, DW'(idx), is_end, $urandom_range(0, 3) != 0, acc);
      if (acc) idx = (idx + 1) % 20;
    end
    n = 0;
    while (part_q.size() != 0 && n < 100) begin
      is_end = (idx == 2) || (idx == 4) || (idx == 6) || (idx == 7) || (idx == 10);
      step(1'b1, DW'(idx), is_end, 1'b1, acc);
      if (acc) idx = (idx + 1) % 20;
      n++;
    end
    drain();

    // Three-word packet only becomes visible after its last word.
    step(1'b1, 8'hA0, 1'b0, 1'b0, acc);
    step(1'b1, 8'hA1, 1'b0, 1'b0, acc);
    step(1'b1, 8'hA2, 1'b1, 1'b0, acc);
    step(1'b0, '0, 1'b0, 1'b0, acc);
    drain();

    // Sixteen words without an end flag: forced close at the full mark.
    for (int i = 0; i < BS; i++) step(1'b1, DW'(8'h40 + i), 1'b0, 1'b0, acc);
    step(1'b0, '0, 1'b0, 1'b0, acc);
    drain();

    // Full of one-word packets, then push and pop together every cycle.
    for (int i = 0; i < BS; i++) step(1'b1, DW'(8'h80 + i), 1'b1, 1'b0, acc);
    for (int i = 0; i < 24; i++) step(1'b1, DW'(8'hC0 + i), 1'b1, 1'b1, acc);
    drain();

    // Reset in the middle of a packet discards it.
    for (int i = 0; i < 5; i++) step(1'b1, DW'(8'h10 + i), 1'b0, 1'b0, acc);
    do_reset();
    step(1'b1, 8'h5A, 1'b0, 1'b0, acc);
    step(1'b1, 8'h5B, 1'b1, 1'b0, acc);
    drain();

    // Pops while empty have no effect; the partial packet later pops intact.
    step(1'b0, '0, 1'b0, 1'b1, acc);
    step(1'b1, 8'h21, 1'b0, 1'b1, acc);
    step(1'b1, 8'h22, 1'b0, 1'b1, acc);
    step(1'b0, '0, 1'b0, 1'b1, acc);
    step(1'b1, 8'h23, 1'b1, 1'b1, acc);
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
